mesh_link_arbiter: RTL and testbench

// - Round-robin arbiter that shares one outgoing mesh link between NUM_REQ packet sources.

---
 rtl/mesh_link_arbiter.sv | 103 ++++++++++
 tb/tb_mesh_link_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mesh_link_arbiter.sv
// mesh_link_arbiter: round-robin arbiter sharing one outgoing mesh link between NUM_REQ packet sources.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid  [NUM_REQ]      per-requester packet valid
//   in_ready  [NUM_REQ]      per-requester accept, one-hot or zero
//   in_pkt    [NUM_REQ*PKT_W] packets, requester i at [i*PKT_W +: PKT_W]
//   in_ctrl   [NUM_REQ*2]    ctrl field per requester (2 = SUM)
//   out_valid/out_ready      one-entry output stage handshake
//   out_pkt   [PKT_W]        held packet
//   out_src   [SRC_W]        index of the requester that sent out_pkt
//   stat_xfers, stat_stalls  saturating transfer / stall counters
//
// Optional feature: define ARB_SUM_PRIORITY_EN to restrict the round-robin
// search to requesters carrying ctrl==SUM whenever any are present.
module mesh_link_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int PKT_W = 55,
    parameter int STAT_W = 16,
    localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       in_valid,
    output logic [NUM_REQ-1:0]       in_ready,
    input  logic [NUM_REQ*PKT_W-1:0] in_pkt,
    input  logic [NUM_REQ*2-1:0]     in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PKT_W-1:0]         out_pkt,
    output logic [SRC_W-1:0]         out_src,
    output logic [STAT_W-1:0]        stat_xfers,
    output logic [STAT_W-1:0]        stat_stalls
);
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   idx;
    logic [SRC_W-1:0]   nxt_ptr;
    logic [NUM_REQ-1:0] cand;
    logic [PKT_W-1:0]   win_pkt;
    logic               found;
    logic               free;
    logic               grant;
`ifdef ARB_SUM_PRIORITY_EN
    logic [NUM_REQ-1:0] sum_set;
    always_comb begin
        sum_set = '0;
        for (int i = 0; i < NUM_REQ; i++)
            sum_set[i] = in_valid[i] & (in_ctrl[2*i +: 2] == 2'd2);
    end
    assign cand = |sum_set ? sum_set : in_valid;
`else
    logic unused_ctrl;
    assign unused_ctrl = ^in_ctrl;
    assign cand = in_valid;
`endif
    // Walk offsets from farthest to nearest so the requester closest to rr_ptr is kept.
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (cand[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == SRC_W'(i)) win_pkt = in_pkt[i*PKT_W +: PKT_W];
    end
    // Gated by rst_n so no requester sees an accept while the stage is held in reset.
    assign free     = rst_n & (!out_valid | out_ready);
    assign grant    = free & found;
    assign in_ready = grant ? NUM_REQ'(1) << win : '0;
    assign nxt_ptr  = int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pkt     <= '0;
            out_src     <= '0;
            rr_ptr      <= '0;
            stat_xfers  <= '0;
            stat_stalls <= '0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_pkt   <= win_pkt;
                out_src   <= win;
                rr_ptr    <= nxt_ptr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready && stat_xfers != '1)
                stat_xfers <= stat_xfers + 1'b1;
            if (out_valid && !out_ready && stat_stalls != '1)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
endmodule

// File: tb/tb_mesh_link_arbiter.sv
// tb_mesh_link_arbiter: directed self-checking bench for mesh_link_arbiter.
module tb_mesh_link_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   in_valid = '0;
    logic [4:0]   in_ready;
    logic [274:0] in_pkt = '0;
    logic [9:0]   in_ctrl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [54:0]  out_pkt;
    logic [2:0]   out_src;
    logic [15:0]  stat_xfers;
    logic [15:0]  stat_stalls;
    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [7:0]   s_in_pkt = 8'h5a;
    logic [1:0]   s_in_ctrl = '0;
    logic         s_out_valid;
    logic         s_out_ready = 1'b0;
    logic [7:0]   s_out_pkt;
    logic         s_out_src;
    logic [1:0]   s_xfers;
    logic [1:0]   s_stalls;
    int           n_chk = 0;
    int           n_pass = 0;
    mesh_link_arbiter #(.NUM_REQ(5), .PKT_W(55), .STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pkt(in_pkt), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_pkt(out_pkt), .out_src(out_src), .stat_xfers(stat_xfers), .stat_stalls(stat_stalls)
    );
    mesh_link_arbiter #(.NUM_REQ(1), .PKT_W(8), .STAT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_pkt(s_in_pkt), .in_ctrl(s_in_ctrl), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_pkt(s_out_pkt), .out_src(s_out_src), .stat_xfers(s_xfers), .stat_stalls(s_stalls)
    );
    always #5 clk = ~clk;
    function automatic logic [54:0] pk(input int i);
        return 55'(64'h0123_4567_0000 + 64'(i) * 64'h1111 + 64'h0abc);
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Drive requests, check the combinational grant, clock once, check the captured packet.
    task automatic grant_step(input logic [4:0] v, input int exp_w, input string tag);
        in_valid = v;
        #1;
        check({tag, "_ready"}, 64'(in_ready), 64'(5'd1 << exp_w));
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_src"}, 64'(out_src), 64'(exp_w));
        check({tag, "_pkt"}, 64'(out_pkt), 64'(pk(exp_w)));
    endtask
    initial begin
        for (int i = 0; i < 5; i++) in_pkt[i*55 +: 55] = pk(i);
        in_valid = 5'h1f;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_xfers", 64'(stat_xfers), 64'd0);
        check("rst_stalls", 64'(stat_stalls), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            grant_step(5'h1f, k % 5, "rr");
            check("rr_xfers", 64'(stat_xfers), 64'(k));
        end
        grant_step(5'b00100, 2, "bp_load");
        out_ready = 1'b0;
        in_valid = 5'h1f;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 64'(in_ready), 64'd0);
            tick();
            check("bp_src", 64'(out_src), 64'd2);
            check("bp_pkt", 64'(out_pkt), 64'(pk(2)));
        end
        check("bp_stalls", 64'(stat_stalls), 64'd3);
        out_ready = 1'b1;
        grant_step(5'h1f, 3, "bp_release");
        check("bp_xfers", 64'(stat_xfers), 64'd7);
        grant_step(5'b10010, 4, "wrap4");
        in_valid = '0;
        #1;
        check("idle_ready", 64'(in_ready), 64'd0);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        tick();
        check("idle_xfers", 64'(stat_xfers), 64'd9);
        grant_step(5'b10010, 1, "wrap1");
        grant_step(5'b10000, 4, "ptr_to0");
        in_ctrl = 10'(2'd2 << 6);
`ifdef ARB_SUM_PRIORITY_EN
        grant_step(5'b01010, 3, "sum_first");
`else
        grant_step(5'b01010, 1, "sum_first");
`endif
        grant_step(5'b01010, 3, "sum_second");
        in_ctrl = '0;
        out_ready = 1'b0;
        #1;
        check("hold_ready", 64'(in_ready), 64'd0);
        tick();
        check("hold_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_pkt", 64'(out_pkt), 64'd0);
        check("arst_xfers", 64'(stat_xfers), 64'd0);
        check("arst_stalls", 64'(stat_stalls), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        grant_step(5'h1f, 0, "post_rst");
        s_in_valid = 1'b1;
        s_out_ready = 1'b1;
        #1;
        check("sat_ready", 64'(s_in_ready), 64'd1);
        for (int k = 0; k < 6; k++) tick();
        check("sat_xfers", 64'(s_xfers), 64'd3);
        check("sat_src", 64'(s_out_src), 64'd0);
        check("sat_pkt", 64'(s_out_pkt), 64'h5a);
        s_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("sat_stalls", 64'(s_stalls), 64'd3);
        check("sat_hold_ready", 64'(s_in_ready), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
